fir_mac_scheduler: RTL and testbench

//  Time-multiplexed MAC sequencer for one FIR_Cascade_HLS stage: drives one shared 16s x 13s -> 29s multiplier.

---
 rtl/fir_mac_scheduler.sv | 170 +++++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: time-multiplexed MAC sequencer for one FIR cascade stage.
// One shared signed multiplier is swept over N_TAPS coefficient/sample pairs,
// one pair per cycle, and the products are summed into a single accumulator.
//
// Ports:
//   ap_clk     clock, all logic on rising edge
//   ap_rst     synchronous active-high reset
//   s_data     input sample (signed), s_valid/s_ready handshake
//   m_data     filtered sample (signed), m_valid/m_ready handshake
//   coef_we    coefficient write strobe with coef_addr / coef_data
//   coef_ack   one-cycle pulse after an accepted coefficient write
//   busy       high while in MAC or OUT
//
// Build option: define FIR_MAC_SAT_EN to round the Q1.12 accumulator to a
// saturated 16-bit output; otherwise m_data is the raw accumulator.
module fir_mac_scheduler #(
  parameter int unsigned N_TAPS = 32,
  parameter int unsigned DIN_W  = 16,
  parameter int unsigned COEF_W = 13,
  parameter int unsigned PROD_W = DIN_W + COEF_W,
  parameter int unsigned ACC_W  = PROD_W + $clog2(N_TAPS),
  localparam int unsigned AW    = $clog2(N_TAPS),
`ifdef FIR_MAC_SAT_EN
  localparam int unsigned OUT_W = 16
`else
  localparam int unsigned OUT_W = ACC_W
`endif
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic signed [DIN_W-1:0]  s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic signed [OUT_W-1:0]  m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_ack,
  output logic                     busy
);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                   state_q;
  logic [AW-1:0]            wr_ptr_q;
  logic [AW-1:0]            base_q;
  logic [AW-1:0]            k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DIN_W-1:0]  line_q [N_TAPS];
  logic signed [COEF_W-1:0] coef_q [N_TAPS];
  logic                     s_ready_q;
  logic                     m_valid_q;
  logic                     busy_q;
  logic                     coef_ack_q;

  // Read index (base - k) mod N_TAPS, computed one bit wider so it works for
  // any N_TAPS, not only powers of two.
  logic [AW:0]   idx_sum;
  logic [AW-1:0] rd_idx;
  assign idx_sum = {1'b0, base_q} + (AW+1)'(N_TAPS) - {1'b0, k_q};
  assign rd_idx  = (idx_sum >= (AW+1)'(N_TAPS)) ? AW'(idx_sum - (AW+1)'(N_TAPS))
                                                : AW'(idx_sum);

  // Shared multiplier: combinational, full precision.
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] samp_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  assign coef_ext = PROD_W'(coef_q[k_q]);
  assign samp_ext = PROD_W'(line_q[rd_idx]);
  assign prod     = coef_ext * samp_ext;
  assign prod_ext = ACC_W'(prod);

  logic coef_addr_ok;
  logic coef_wr;
  logic accept;
  assign coef_addr_ok = ({1'b0, coef_addr} < (AW+1)'(N_TAPS));
  assign coef_wr      = coef_we && coef_addr_ok && (state_q == StIdle);
  assign accept       = s_valid && s_ready_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      base_q     <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      s_ready_q  <= 1'b1;
      m_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      coef_ack_q <= 1'b0;
      for (int unsigned i = 0; i < N_TAPS; i++) begin
        line_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      coef_ack_q <= coef_wr;
      // Written on the accept edge too, so the new value serves that sample.
      if (coef_wr) begin
        coef_q[coef_addr] <= coef_data;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            line_q[wr_ptr_q] <= s_data;
            base_q           <= wr_ptr_q;
            wr_ptr_q         <= (wr_ptr_q == AW'(N_TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
            k_q              <= '0;
            acc_q            <= '0;
            state_q          <= StMac;
            s_ready_q        <= 1'b0;
            busy_q           <= 1'b1;
          end
        end
        StMac: begin
          acc_q <= acc_q + prod_ext;
          if (k_q == AW'(N_TAPS - 1)) begin
            k_q       <= '0;
            state_q   <= StOut;
            m_valid_q <= 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StOut: begin
          if (m_ready) begin
            state_q   <= StIdle;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          s_ready_q <= 1'b1;
          m_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign m_valid  = m_valid_q;
  assign busy     = busy_q;
  assign coef_ack = coef_ack_q;

`ifdef FIR_MAC_SAT_EN
  // Round half up at the Q1.12 point, then clamp to the 16-bit range.
  localparam logic signed [ACC_W:0] SatMax = (ACC_W+1)'(32767);
  localparam logic signed [ACC_W:0] SatMin = (ACC_W+1)'(-32768);
  logic signed [ACC_W:0] acc_rnd;
  logic signed [ACC_W:0] acc_shr;
  assign acc_rnd = (ACC_W+1)'(acc_q) + (ACC_W+1)'(2048);
  assign acc_shr = acc_rnd >>> 12;
  always_comb begin
    m_data = acc_shr[15:0];
    if (acc_shr > SatMax) begin
      m_data = 16'sh7fff;
    end else if (acc_shr < SatMin) begin
      m_data = 16'sh8000;
    end
  end
`else
  assign m_data = acc_q;
`endif

endmodule

// File: tb/tb_fir_mac_scheduler.sv
module tb_fir_mac_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 2;
`ifdef FIR_MAC_SAT_EN
  localparam int unsigned OUT_W = 16;
`else
  localparam int unsigned OUT_W = 31;
`endif

  logic                     ap_clk = 1'b0;
  logic                     ap_rst;
  logic signed [15:0]       s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic signed [OUT_W-1:0]  m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [12:0]       coef_data;
  logic                     coef_ack;
  logic                     busy;

  fir_mac_scheduler #(.N_TAPS(N)) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .coef_ack (coef_ack),
    .busy     (busy)
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  longint coef_m [N];
  longint hist   [N];

  typedef struct {
    logic signed [15:0] x;
    longint             y;
  } vec_t;

  vec_t imp [5];
  vec_t ext [8];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint expv(input longint raw);
`ifdef FIR_MAC_SAT_EN
    longint r;
    r = (raw + 2048) >>> 12;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
`else
    return raw;
`endif
  endfunction

  function automatic longint model_y();
    longint s = 0;
    for (int k = 0; k < N; k++) s += coef_m[k] * hist[k];
    return s;
  endfunction

  function automatic void shift_in(input longint x);
    for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < N; k++) begin
      coef_m[k] = 0;
      hist[k]   = 0;
    end
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    model_clear();
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic signed [12:0] d,
                            input bit exp_ack);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
    coef_we = 1'b0;
    chk("coef_ack_pulse", longint'(coef_ack), longint'(exp_ack));
    if (exp_ack) coef_m[a] = d;
    tick();
    chk("coef_ack_clear", longint'(coef_ack), 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (!s_ready) chk("s_ready_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!m_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!m_valid) chk("m_valid_timeout", 0, 1);
  endtask

  // Send one sample (optionally with a same-edge coef write), hold m_ready low
  // for bp cycles once m_valid is up, then consume the output.
  task automatic send(input logic signed [15:0] x, input bit cw, input logic [AW-1:0] ca,
                      input logic signed [12:0] cd, input int bp,
                      output longint got, output int lat);
    longint exp_y;
    wait_ready();
    s_data    = x;
    s_valid   = 1'b1;
    coef_we   = cw;
    coef_addr = ca;
    coef_data = cd;
    tick();
    s_valid = 1'b0;
    coef_we = 1'b0;
    if (cw) coef_m[ca] = cd;
    shift_in(x);
    exp_y = expv(model_y());
    wait_valid(lat);
    got = longint'(m_data);
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_m_valid", longint'(m_valid), 1);
      chk("bp_m_data", longint'(m_data), exp_y);
      chk("bp_s_ready", longint'(s_ready), 0);
      chk("bp_busy", longint'(busy), 1);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("m_valid_fall", longint'(m_valid), 0);
  endtask

  task automatic send_chk(input string name, input logic signed [15:0] x);
    longint got;
    int     lat;
    send(x, 1'b0, '0, '0, 0, got, lat);
    chk(name, got, expv(model_y()));
  endtask

  task automatic load_ramp();
    write_coef(2'd0, 13'sd1, 1'b1);
    write_coef(2'd1, 13'sd2, 1'b1);
    write_coef(2'd2, 13'sd3, 1'b1);
    write_coef(2'd3, 13'sd4, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint got;
    int     lat;
    int     seen;

    imp[0].x = 16'sd1; imp[0].y = 1;
    imp[1].x = 16'sd0; imp[1].y = 2;
    imp[2].x = 16'sd0; imp[2].y = 3;
    imp[3].x = 16'sd0; imp[3].y = 4;
    imp[4].x = 16'sd0; imp[4].y = 0;

    ext[0].x = -16'sd32768; ext[0].y = 134217728;
    ext[1].x = -16'sd32768; ext[1].y = 268435456;
    ext[2].x = -16'sd32768; ext[2].y = 402653184;
    ext[3].x = -16'sd32768; ext[3].y = 536870912;
    ext[4].x = 16'sd32767;  ext[4].y = 268439552;
    ext[5].x = 16'sd32767;  ext[5].y = 8192;
    ext[6].x = 16'sd32767;  ext[6].y = -268423168;
    ext[7].x = 16'sd32767;  ext[7].y = -536854528;

    ap_rst = 1'b1; s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    tick();
    tick();
    ap_rst = 1'b0;
    model_clear();

    // Reset state
    chk("rst_s_ready", longint'(s_ready), 1);
    chk("rst_m_valid", longint'(m_valid), 0);
    chk("rst_coef_ack", longint'(coef_ack), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_m_data", longint'(m_data), 0);

    // Impulse response
    load_ramp();
    for (int i = 0; i < 5; i++) begin
      send(imp[i].x, 1'b0, '0, '0, 0, got, lat);
      chk("impulse", got, expv(imp[i].y));
      if (i == 0) chk("latency", longint'(lat), longint'(N));
    end

    // Latency and backpressure
    send(16'sd7, 1'b0, '0, '0, 5, got, lat);
    chk("bp_latency", longint'(lat), longint'(N));
    chk("bp_value", got, expv(model_y()));

    // Extremes
    do_reset();
    for (int k = 0; k < N; k++) write_coef(AW'(k), -13'sd4096, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(ext[i].x, 1'b0, '0, '0, 0, got, lat);
      chk("extreme", got, expv(ext[i].y));
    end

    // Coefficient write during MAC is dropped
    do_reset();
    load_ramp();
    send_chk("mw_pre0", 16'sd1);
    send_chk("mw_pre1", 16'sd0);
    wait_ready();
    s_data = 16'sd0; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    shift_in(0);
    tick();
    tick();
    coef_we = 1'b1; coef_addr = 2'd2; coef_data = 13'sd100;
    tick();
    coef_we = 1'b0;
    chk("mac_write_no_ack", longint'(coef_ack), 0);
    wait_valid(lat);
    chk("mac_write_old_coef", longint'(m_data), expv(3));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    write_coef(2'd2, 13'sd100, 1'b1);
    send_chk("mw_post0", 16'sd1);
    send_chk("mw_post1", 16'sd0);
    send_chk("mw_post2", 16'sd0);

    // Reset while in MAC at k=1
    do_reset();
    load_ramp();
    send_chk("ra_pre0", 16'sd5);
    send_chk("ra_pre1", 16'sd6);
    wait_ready();
    s_data = 16'sd7; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    model_clear();
    chk("abort_s_ready", longint'(s_ready), 1);
    chk("abort_m_valid", longint'(m_valid), 0);
    chk("abort_busy", longint'(busy), 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_valid) seen++;
      tick();
    end
    chk("abort_no_emit", longint'(seen), 0);
    load_ramp();
    send(16'sd1, 1'b0, '0, '0, 0, got, lat);
    chk("abort_impulse0", got, expv(1));
    send(16'sd0, 1'b0, '0, '0, 0, got, lat);
    chk("abort_impulse1", got, expv(2));

    // Random samples/coefficients across delay-line wrap
    do_reset();
    for (int k = 0; k < N; k++) write_coef(AW'(k), 13'($urandom()), 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        send(16'($urandom()), 1'b1, 2'd1, 13'($urandom()), 0, got, lat);
        chk("wrap_same_edge_coef", got, expv(model_y()));
      end else begin
        send_chk("wrap", 16'($urandom()));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
